// File: rtl/opcode_tag_decoder_pkg.sv
// -----------------------------------------------------------------------------
// opcode_tag_decoder_pkg
// Shared types and constants for the opcodeEnA tag encoding.
//   tag = OPCODEABASE_<type> + offset, so type = tag[8:6] and offset = tag[5:0].
// Contents:
//   opcodeTagT     9-bit encoded tag
//   opcodeEnumT    3-bit command type
//   OPCODEABASE_*  per-type tag base values
//   opcodeDecSt    decoded {op_type, offset} pair carried through the skid buffer
//   occStateT      occupancy states of the 2-entry skid buffer
//   tag_is_valid / decode_tag helper functions
// -----------------------------------------------------------------------------
package opcode_tag_decoder_pkg;

  typedef logic [8:0] opcodeTagT;

  typedef enum logic [2:0] {
    OPCODEATYPE_READ  = 3'd0,
    OPCODEATYPE_WRITE = 3'd1,
    OPCODEATYPE_WAIT  = 3'd2,
    OPCODEATYPE_FLUSH = 3'd3,
    OPCODEATYPE_TRIM  = 3'd4
  } opcodeEnumT;

  localparam opcodeTagT OPCODEABASE_READ  = 9'h000;
  localparam opcodeTagT OPCODEABASE_WRITE = 9'h040;
  localparam opcodeTagT OPCODEABASE_WAIT  = 9'h080;
  localparam opcodeTagT OPCODEABASE_FLUSH = 9'h0C0;
  localparam opcodeTagT OPCODEABASE_TRIM  = 9'h100;

  localparam int OPCODE_OFFSET_W = 6;
  localparam opcodeEnumT OPCODE_TYPE_MAX = OPCODEATYPE_TRIM;

  // "type" is a reserved word, so the type field is called op_type.
  typedef struct packed {
    opcodeEnumT                  op_type;
    logic [OPCODE_OFFSET_W-1:0]  offset;
  } opcodeDecSt;

  localparam int OPCODE_DEC_W = $bits(opcodeDecSt);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occStateT;

  // Type fields above TRIM (tags 0x140..0x1FF) carry no command.
  function automatic logic tag_is_valid(input opcodeTagT tag);
    return (tag[8:6] <= OPCODE_TYPE_MAX);
  endfunction

  function automatic opcodeDecSt decode_tag(input opcodeTagT tag);
    opcodeDecSt d;
    d.op_type = opcodeEnumT'(tag[8:6]);
    d.offset  = tag[OPCODE_OFFSET_W-1:0];
    return d;
  endfunction

endpackage

// File: rtl/opcode_skid_buffer.sv
// -----------------------------------------------------------------------------
// opcode_skid_buffer
// Generic 2-entry ready/valid skid buffer: an output register plus one skid
// register. Full throughput; in_ready is registered (low only when the skid
// register is occupied). Ordering is preserved.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     upstream handshake, in_data W bits
//   out_valid/out_ready   downstream handshake, out_data W bits (registered)
// -----------------------------------------------------------------------------
module opcode_skid_buffer
  import opcode_tag_decoder_pkg::*;
#(
  parameter int W = OPCODE_DEC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  occStateT       state_r;
  occStateT       state_s;
  logic           in_ready_r;
  logic           out_valid_r;
  logic [W-1:0]   out_data_r;
  logic [W-1:0]   skid_data_r;
  logic           in_xfer_s;
  logic           out_xfer_s;
  logic           load_out_in_s;
  logic           load_out_skid_s;
  logic           load_skid_s;

  assign in_xfer_s  = in_valid & in_ready_r;
  assign out_xfer_s = out_valid_r & out_ready;

  // Occupancy next-state and register-load selects.
  always_comb begin
    state_s         = state_r;
    load_out_in_s   = 1'b0;
    load_out_skid_s = 1'b0;
    load_skid_s     = 1'b0;
    case (state_r)
      OCC_EMPTY: begin
        if (in_xfer_s) begin
          state_s       = OCC_ONE;
          load_out_in_s = 1'b1;
        end else begin
          state_s = OCC_EMPTY;
        end
      end
      OCC_ONE: begin
        if (in_xfer_s && out_xfer_s) begin
          state_s       = OCC_ONE;
          load_out_in_s = 1'b1;
        end else if (in_xfer_s) begin
          // Output held: park the new entry in the skid register.
          state_s     = OCC_TWO;
          load_skid_s = 1'b1;
        end else if (out_xfer_s) begin
          state_s = OCC_EMPTY;
        end else begin
          state_s = OCC_ONE;
        end
      end
      OCC_TWO: begin
        // in_ready is low here, so only a drain can happen.
        if (out_xfer_s) begin
          state_s         = OCC_ONE;
          load_out_skid_s = 1'b1;
        end else begin
          state_s = OCC_TWO;
        end
      end
      default: begin
        state_s = OCC_EMPTY;
      end
    endcase
  end

  // State, handshake flags and data registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= OCC_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= {W{1'b0}};
      skid_data_r <= {W{1'b0}};
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s != OCC_TWO);
      out_valid_r <= (state_s != OCC_EMPTY);
      if (load_out_in_s) begin
        out_data_r <= in_data;
      end else if (load_out_skid_s) begin
        out_data_r <= skid_data_r;
      end
      if (load_skid_s) begin
        skid_data_r <= in_data;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule

// File: rtl/opcode_tag_decoder.sv
// -----------------------------------------------------------------------------
// opcode_tag_decoder
// Splits a stream of 9-bit opcodeTagT tags into {opcodeEnumT, 6-bit offset}.
// Valid tags pass through a 2-entry skid buffer (registered output, one-cycle
// latency, full throughput). Invalid tags (type field > TRIM) are consumed,
// never forwarded, and reported via err_pulse / err_sticky / err_tag.
// Optional feature macro: OPCODE_TAG_DECODER_STATS_EN
//   defined   : five saturating CNT_W per-type output-transfer counters,
//               read through stat_sel -> stat_cnt (registered, 1-cycle latency)
//   undefined : no counters, stat_cnt tied to 0
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   in_valid/in_ready/in_tag        tag input handshake
//   out_valid/out_ready             decoded command handshake
//   out_type, out_offset            decoded command
//   err_pulse, err_sticky, err_tag  invalid-tag reporting; err_clr clears
//   stat_sel, stat_cnt              statistics read port
// -----------------------------------------------------------------------------
module opcode_tag_decoder
  import opcode_tag_decoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8:0]       in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_type,
  output logic [5:0]       out_offset,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [8:0]       err_tag,
  input  logic             err_clr,
  input  logic [2:0]       stat_sel,
  output logic [CNT_W-1:0] stat_cnt
);

  opcodeDecSt  in_dec_s;
  opcodeDecSt  out_dec_s;
  logic        tag_ok_s;
  logic        in_xfer_s;
  logic        bad_xfer_s;
  logic        out_xfer_s;
  logic        err_pulse_r;
  logic        err_sticky_r;
  opcodeTagT   err_tag_r;

  assign tag_ok_s   = tag_is_valid(in_tag);
  assign in_dec_s   = decode_tag(in_tag);
  assign in_xfer_s  = in_valid & in_ready;
  assign bad_xfer_s = in_xfer_s & ~tag_ok_s;
  assign out_xfer_s = out_valid & out_ready;

  // Invalid tags never enter the buffer, but are still consumed because
  // in_ready comes straight from the buffer.
  opcode_skid_buffer #(
    .W (OPCODE_DEC_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid & tag_ok_s),
    .in_ready  (in_ready),
    .in_data   (in_dec_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_dec_s)
  );

  assign out_type   = out_dec_s.op_type;
  assign out_offset = out_dec_s.offset;

  // Error capture: first error since clear wins; an error in the same cycle
  // as err_clr takes priority over the clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_pulse_r  <= 1'b0;
      err_sticky_r <= 1'b0;
      err_tag_r    <= 9'h000;
    end else begin
      err_pulse_r <= bad_xfer_s;
      if (bad_xfer_s) begin
        err_sticky_r <= 1'b1;
        if (!err_sticky_r || err_clr) begin
          err_tag_r <= in_tag;
        end
      end else if (err_clr) begin
        err_sticky_r <= 1'b0;
        err_tag_r    <= 9'h000;
      end
    end
  end

  assign err_pulse  = err_pulse_r;
  assign err_sticky = err_sticky_r;
  assign err_tag    = err_tag_r;

`ifdef OPCODE_TAG_DECODER_STATS_EN
  logic [CNT_W-1:0] cnt_r [5];
  logic [CNT_W-1:0] stat_cnt_r;

  // Per-type saturating counters and registered read port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
      stat_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (out_xfer_s && (cnt_r[out_type] != {CNT_W{1'b1}})) begin
        cnt_r[out_type] <= cnt_r[out_type] + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (stat_sel <= 3'd4) begin
        stat_cnt_r <= cnt_r[stat_sel];
      end else begin
        stat_cnt_r <= {CNT_W{1'b0}};
      end
    end
  end

  assign stat_cnt = stat_cnt_r;
`else
  logic stat_unused_s;
  assign stat_unused_s = (^stat_sel) ^ out_xfer_s;
  assign stat_cnt      = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_opcode_tag_decoder.sv
module tb_opcode_tag_decoder;
  import opcode_tag_decoder_pkg::*;

`ifdef OPCODE_TAG_DECODER_STATS_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [8:0]       in_tag = 9'h000;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [2:0]       out_type;
  logic [5:0]       out_offset;
  logic             err_pulse;
  logic             err_sticky;
  logic [8:0]       err_tag;
  logic             err_clr = 1'b0;
  logic [2:0]       stat_sel = 3'd0;
  logic [CNT_W-1:0] stat_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  opcode_tag_decoder #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_type   (out_type),
    .out_offset (out_offset),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .err_tag    (err_tag),
    .err_clr    (err_clr),
    .stat_sel   (stat_sel),
    .stat_cnt   (stat_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if ({out_type, out_offset} !== 9'h000) begin n_bad++; $display("FAIL reset_out_data: got %h expected 000", {out_type, out_offset}); end
    n_cmp++; if ({err_pulse, err_sticky, err_tag} !== 11'h000) begin n_bad++; $display("FAIL reset_err: got %h expected 000", {err_pulse, err_sticky, err_tag}); end
    n_cmp++; if (stat_cnt !== {CNT_W{1'b0}}) begin n_bad++; $display("FAIL reset_stat: got %0d expected 0", stat_cnt); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_tag    = 9'h045;
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b expected 1", out_valid); end
    n_cmp++; if (out_type !== 3'd1) begin n_bad++; $display("FAIL single_type: got %0d expected 1", out_type); end
    n_cmp++; if (out_offset !== 6'd5) begin n_bad++; $display("FAIL single_offset: got %0d expected 5", out_offset); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] tags  [3] = '{9'h000, 9'h0BF, 9'h13F};
    logic [2:0] etype [3] = '{3'd0, 3'd2, 3'd4};
    logic [5:0] eoff  [3] = '{6'h00, 6'h3F, 6'h3F};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_tag   = tags[i];
      step();
      n_cmp++; if ({out_valid, out_type, out_offset} !== {1'b1, etype[i], eoff[i]})
        begin n_bad++; $display("FAIL b2b_out[%0d]: got v=%b t=%0d o=%h expected v=1 t=%0d o=%h", i, out_valid, out_type, out_offset, etype[i], eoff[i]); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, in_ready); end
    end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_errors();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_tag    = 9'h140;
    step();
    n_cmp++; if ({out_valid, err_pulse, err_sticky, err_tag} !== {1'b0, 1'b1, 1'b1, 9'h140})
      begin n_bad++; $display("FAIL err_first: got v=%b p=%b s=%b t=%h expected v=0 p=1 s=1 t=140", out_valid, err_pulse, err_sticky, err_tag); end
    in_tag = 9'h1FF;
    step();
    in_valid = 1'b0;
    n_cmp++; if ({out_valid, err_pulse, err_sticky, err_tag} !== {1'b0, 1'b1, 1'b1, 9'h140})
      begin n_bad++; $display("FAIL err_second: got v=%b p=%b s=%b t=%h expected v=0 p=1 s=1 t=140", out_valid, err_pulse, err_sticky, err_tag); end
    step();
    n_cmp++; if ({out_valid, err_pulse, err_sticky} !== 3'b001)
      begin n_bad++; $display("FAIL err_hold: got v=%b p=%b s=%b expected v=0 p=0 s=1", out_valid, err_pulse, err_sticky); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_cmp++; if ({err_sticky, err_tag} !== 10'h000) begin n_bad++; $display("FAIL err_clear: got s=%b t=%h expected s=0 t=000", err_sticky, err_tag); end
    // Set an error, then clear with a new error in the same cycle.
    in_valid = 1'b1;
    in_tag   = 9'h150;
    step();
    in_tag  = 9'h1C3;
    err_clr = 1'b1;
    step();
    in_valid = 1'b0;
    err_clr  = 1'b0;
    n_cmp++; if ({err_sticky, err_tag} !== {1'b1, 9'h1C3}) begin n_bad++; $display("FAIL err_clr_collide: got s=%b t=%h expected s=1 t=1c3", err_sticky, err_tag); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [8:0] tags  [4] = '{9'h041, 9'h08A, 9'h0D3, 9'h11C};
    logic [2:0] etype [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [5:0] eoff  [4] = '{6'h01, 6'h0A, 6'h13, 6'h1C};
    logic [2:0] rx_type [4];
    logic [5:0] rx_off  [4];
    int  sent = 0;
    int  got = 0;
    int  cycles = 0;
    logic acc;
    logic drn;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_tag   = tags[sent];
      acc      = in_ready;
      step();
      if (acc) sent++;
      n_cmp++; if (in_ready !== (k == 0)) begin n_bad++; $display("FAIL bp_in_ready[%0d]: got %b expected %b", k, in_ready, (k == 0)); end
      n_cmp++; if ({out_valid, out_type, out_offset} !== {1'b1, 3'd1, 6'h01})
        begin n_bad++; $display("FAIL bp_hold[%0d]: got v=%b t=%0d o=%h expected v=1 t=1 o=01", k, out_valid, out_type, out_offset); end
    end
    n_cmp++; if (sent !== 2) begin n_bad++; $display("FAIL bp_accepted: got %0d expected 2", sent); end
    out_ready = 1'b1;
    while ((got < 4) && (cycles < 30)) begin
      in_valid = (sent < 4);
      in_tag   = (sent < 4) ? tags[sent] : 9'h000;
      acc      = in_valid && in_ready;
      drn      = out_valid && out_ready;
      if (drn) begin
        rx_type[got] = out_type;
        rx_off[got]  = out_offset;
        got++;
      end
      step();
      if (acc) sent++;
      cycles++;
    end
    in_valid = 1'b0;
    n_cmp++; if (got !== 4) begin n_bad++; $display("FAIL bp_count: got %0d expected 4 within cycle budget", got); end
    for (int i = 0; i < got; i++) begin
      n_cmp++; if ({rx_type[i], rx_off[i]} !== {etype[i], eoff[i]})
        begin n_bad++; $display("FAIL bp_order[%0d]: got t=%0d o=%h expected t=%0d o=%h", i, rx_type[i], rx_off[i], etype[i], eoff[i]); end
    end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_tag    = 9'h041;
    step();
    in_tag = 9'h08A;
    step();
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_full: got in_ready=%b expected 0", in_ready); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_bad++; $display("FAIL rstmid_flags: got v=%b r=%b expected v=0 r=1", out_valid, in_ready); end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_stale[%0d]: got %b expected 0", k, out_valid); end
    end
  endtask

  task automatic test_stats();
`ifdef OPCODE_TAG_DECODER_STATS_EN
    int sent = 0;
    int cycles = 0;
    logic acc;
    rst_n = 1'b0;
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    while ((sent < 20) && (cycles < 60)) begin
      in_valid = 1'b1;
      in_tag   = 9'h040 + 9'(sent);
      acc      = in_ready;
      step();
      if (acc) sent++;
      cycles++;
    end
    in_valid = 1'b0;
    step();
    step();
    stat_sel = 3'd1;
    step();
    n_cmp++; if (stat_cnt !== 4'd15) begin n_bad++; $display("FAIL stat_write: got %0d expected 15", stat_cnt); end
    stat_sel = 3'd0;
    step();
    n_cmp++; if (stat_cnt !== 4'd0) begin n_bad++; $display("FAIL stat_read: got %0d expected 0", stat_cnt); end
    stat_sel = 3'd6;
    step();
    n_cmp++; if (stat_cnt !== 4'd0) begin n_bad++; $display("FAIL stat_sel6: got %0d expected 0", stat_cnt); end
`else
    stat_sel = 3'd1;
    step();
    n_cmp++; if (stat_cnt !== {CNT_W{1'b0}}) begin n_bad++; $display("FAIL stat_tied: got %0d expected 0", stat_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
